// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-N stream demultiplexer.
// The drop counter width, its saturation limit and the per-channel register state live here.
package stream_demux_pkg;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
    return (value == DROP_MAX) ? value : value + DROP_W'(1);
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side handshake bundle of the demux.
// The slave modport is the demux itself; the master modport drives it.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH)
);

  logic                   mode;
  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_W-1:0]      s_data;
  logic [SEL_W-1:0]       s_sel;
  logic [N_CH-1:0]        m_valid;
  logic [N_CH-1:0]        m_ready;
  logic [N_CH*DATA_W-1:0] m_data;
  logic [SEL_W-1:0]       rr_ptr;
  logic [DROP_W-1:0]      drop_cnt;

  modport slave (
    input  mode, s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data, rr_ptr, drop_cnt
  );

  modport master (
    output mode, s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data, rr_ptr, drop_cnt
  );

endinterface

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register for a single demux channel.
// A load wins over a drain, so a simultaneous drain and load keeps the register full with new data.
module demux_out_reg
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              avail_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  ch_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Data is kept after a drain so an empty channel still shows the last word written.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = CH_FULL;
      data_d  = data_i;
    end else if (ready_i) begin
      state_d = CH_EMPTY;
    end
  end

  assign avail_o = (state_q == CH_EMPTY) | ready_i;
  assign valid_o = (state_q == CH_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with addressed or round-robin steering.
// Holds the target decode, input ready mux, round-robin pointer and saturating drop counter.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input logic           clk,
  input logic           rst,
  stream_demux_if.slave bus
);

  logic [SEL_W-1:0]       tgtSel;
  logic                   tgtHit;
  logic                   sReady;
  logic                   accept;
  logic                   dropWord;
  logic [N_CH-1:0]        chAvail;
  logic [N_CH-1:0]        chLoad;
  logic [N_CH-1:0]        chValid;
  logic [N_CH*DATA_W-1:0] chData;
  logic [SEL_W-1:0]       rrPtr_q, rrPtr_d;
  logic [DROP_W-1:0]      dropCnt_q, dropCnt_d;

  // A select that matches no channel leaves sReady high so the word is swallowed as a drop.
  always_comb begin
    tgtSel = bus.mode ? rrPtr_q : bus.s_sel;
    tgtHit = 1'b0;
    sReady = 1'b1;
    chLoad = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (tgtSel == SEL_W'(k)) begin
        tgtHit    = 1'b1;
        sReady    = chAvail[k];
        chLoad[k] = bus.s_valid & chAvail[k];
      end
    end
    accept   = bus.s_valid & sReady;
    dropWord = accept & ~tgtHit;
  end

  always_comb begin
    rrPtr_d   = rrPtr_q;
    dropCnt_d = dropCnt_q;
    if (accept && bus.mode) begin
      rrPtr_d = (rrPtr_q == SEL_W'(N_CH - 1)) ? '0 : rrPtr_q + 1'b1;
    end
    if (dropWord) begin
      dropCnt_d = sat_inc(dropCnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q   <= '0;
      dropCnt_q <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    demux_out_reg #(
      .DATA_W(DATA_W)
    ) u_reg (
      .clk    (clk),
      .rst    (rst),
      .load_i (chLoad[g]),
      .ready_i(bus.m_ready[g]),
      .data_i (bus.s_data),
      .avail_o(chAvail[g]),
      .valid_o(chValid[g]),
      .data_o (chData[g*DATA_W +: DATA_W])
    );
  end

  assign bus.s_ready  = sReady;
  assign bus.m_valid  = chValid;
  assign bus.m_data   = chData;
  assign bus.rr_ptr   = rrPtr_q;
  assign bus.drop_cnt = dropCnt_q;

endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1toN

Registered, handshaked 1-to-N stream demultiplexer, the parametrised successor to the team's combinational 1:4 demux. One input stream is steered to one of N_CH output channels, chosen either by an explicit select or by an internal round-robin pointer. Each channel has its own one-entry output register with valid/ready flow control. It sits between a single producer and N independent consumers in datapath fan-out.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- N_CH, 4, number of output channels (2..16; need not be a power of two)
- SEL_W, $clog2(N_CH), select width (derived; do not override)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = addressed (use s_sel), 1 = round-robin (use internal pointer)
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  DATA_W  input payload
- s_sel  in  SEL_W  target channel in addressed mode
- m_valid  out  N_CH  per-channel output valid
- m_ready  in  N_CH  per-channel consumer ready
- m_data  out  N_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W]
- rr_ptr  out  SEL_W  current round-robin pointer
- drop_cnt  out  16  saturating count of dropped words (out-of-range select)

## Operation
- Target channel t: mode=0 → s_sel; mode=1 → rr_ptr. mode is sampled every cycle, with no protocol restriction.
- Each channel register is EMPTY (m_valid=0) or FULL (m_valid=1).
  - EMPTY→FULL on accept into that channel.
  - FULL→EMPTY on m_ready with no new accept.
  - FULL stays FULL on a simultaneous drain and accept; the new data replaces the old.
- s_ready = (channel t EMPTY) | m_ready[t]. s_ready is combinational from m_ready, mode, s_sel and rr_ptr. It never depends on s_valid.
- Out-of-range select (mode=0, s_sel ≥ N_CH):
  - s_ready=1 and the word is consumed.
  - No channel is written.
  - drop_cnt increments and saturates at 16'hFFFF.
- Round-robin:
  - rr_ptr advances by 1 on each accepted transfer in mode=1 and wraps N_CH-1→0.
  - rr_ptr holds in mode=0 and on stalls. It is never out of range.
- m_data[k] holds its value while FULL and not drained. Data is don't-care while EMPTY, but implemented as the last value written.
- Non-target channels drain independently and concurrently.

## Timing
- Reset values: all m_valid=0, m_data=0, rr_ptr=0, drop_cnt=0. s_ready after reset = 1 for any in-range target.
- Reset asserted mid-operation clears all state immediately (asynchronously). Buffered words are lost, with no partial output.
- Latency: a word accepted at edge n appears as m_valid[t]=1 at the output after edge n. That is one cycle.
- Throughput: one word per cycle into any channel whose m_ready is held high. Back-to-back writes to the same channel are allowed.
- m_valid[k] must not drop without m_ready[k] (AXI-style stability). m_data[k] is stable while m_valid[k] & !m_ready[k].
- Simultaneous rst deassertion and s_valid: no acceptance on the first edge after deassertion. Benches wait ≥1 cycle.

## Structure
- Package stream_demux_pkg holds:
  - the localparam DROP_W = 16
  - the saturating-max constant
  - the channel-state enum {CH_EMPTY, CH_FULL}
- Sub-module demux_out_reg (DATA_W): one-entry valid/ready register with load, drain and simultaneous load+drain. It is instantiated N_CH times in a generate loop.
- Top level contains the target decode, s_ready mux, rr_ptr counter and drop counter.

## Test plan
- Addressed fill: N_CH=4, all m_ready=0, send 0xA0..0xA3 with s_sel=0..3 → m_valid=4'b1111, and each channel holds its word. A fifth word to channel 2 sees s_ready=0 until m_ready[2]=1.
- Round-robin streaming: mode=1, all m_ready=1, send 8 words 0x10..0x17 → channel k receives 0x1k then 0x1(k+4). rr_ptr sequence is 0,1,2,3,0,1,2,3,0. There is one accept per cycle.
- Simultaneous drain+load: channel 1 FULL with 0x55, m_ready[1]=1, accept 0x66 to channel 1 in the same cycle → m_valid[1] stays 1, and m_data[1] becomes 0x66 next cycle.
- Out-of-range drop: N_CH=3, mode=0, s_sel=3, send 5 words → s_ready=1 throughout, no m_valid change, drop_cnt=5. Preload drop_cnt near 0xFFFF and confirm it saturates.
- Async reset mid-stream: rr_ptr=2 with channels 0 and 2 FULL, pulse rst between edges → all outputs clear immediately without a clock. The next round-robin word goes to channel 0.
- Random backpressure: random s_valid/s_sel/mode/m_ready for 10k cycles against a scoreboard → no loss, no duplication, per-channel order preserved, and m_data stable while stalled.
